// File: rtl/td4_run_ctrl.sv
// rtl/td4_run_ctrl.sv - TD4 run/step/halt/breakpoint and program-load sequencer
// Paces the CPU clock enable in RUN and streams program words into RAM in LOAD.
module td4_run_ctrl #(
    parameter int TICK_DIV = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run_req,
    input  logic       step_req,
    input  logic       halt_req,
    input  logic       bp_en,
    input  logic [3:0] bp_addr,
    input  logic [3:0] cpu_ip,
    input  logic       load_valid,
    input  logic [3:0] load_addr,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       ram_we,
    output logic [3:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       cpu_en,
    output logic       cpu_rst_n,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_LOAD = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICK_DIV - 1);

    state_t           cur_st;
    state_t           nxt_st;
    logic [CNT_W-1:0] div_cnt;
    logic [CNT_W-1:0] div_cnt_nxt;
    logic             skip;
    logic             skip_nxt;
    logic             cpu_en_nxt;
    logic             tc;
    logic             bp_hit;

    assign tc     = (div_cnt == TC_VAL);
    // The skip flag masks the breakpoint so a resume at the breakpoint address makes progress.
    assign bp_hit = bp_en && (cpu_ip == bp_addr) && !skip;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_st     <= ST_IDLE;
            div_cnt    <= '0;
            skip       <= 1'b0;
            cpu_en     <= 1'b0;
            load_ready <= 1'b0;
            cpu_rst_n  <= 1'b0;
        end else begin
            cur_st     <= nxt_st;
            div_cnt    <= div_cnt_nxt;
            skip       <= skip_nxt;
            cpu_en     <= cpu_en_nxt;
            load_ready <= (nxt_st == ST_LOAD);
            cpu_rst_n  <= (nxt_st != ST_LOAD);
        end
    end

    always_comb begin
        nxt_st      = cur_st;
        div_cnt_nxt = div_cnt;
        skip_nxt    = skip;
        cpu_en_nxt  = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                div_cnt_nxt = '0;
                if (load_valid) begin
                    nxt_st = ST_LOAD;
                end else if (run_req) begin
                    nxt_st   = ST_RUN;
                    skip_nxt = 1'b1;
                end else if (step_req) begin
                    nxt_st     = ST_STEP;
                    cpu_en_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    nxt_st      = ST_IDLE;
                    div_cnt_nxt = '0;
                end else if (tc) begin
                    div_cnt_nxt = '0;
                    if (bp_hit) begin
                        nxt_st = ST_IDLE;
                    end else begin
                        cpu_en_nxt = 1'b1;
                        skip_nxt   = 1'b0;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + CNT_W'(1);
                end
            end
            ST_STEP: begin
                nxt_st = ST_IDLE;
            end
            ST_LOAD: begin
                if (!load_valid) begin
                    nxt_st = ST_IDLE;
                end
            end
            default: begin
                nxt_st = ST_IDLE;
            end
        endcase
    end

    assign state     = cur_st;
    assign ram_we    = load_valid & load_ready;
    assign ram_addr  = load_addr;
    assign ram_wdata = load_data;

endmodule

// File: tb/tb_td4_run_ctrl.sv
// tb/tb_td4_run_ctrl.sv - scoreboard bench for td4_run_ctrl with a toy CPU instruction pointer
module tb_td4_run_ctrl;

    localparam int TD = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       run_req = 1'b0;
    logic       step_req = 1'b0;
    logic       halt_req = 1'b0;
    logic       bp_en = 1'b0;
    logic [3:0] bp_addr = 4'd0;
    logic [3:0] cpu_ip = 4'd0;
    logic       load_valid = 1'b0;
    logic [3:0] load_addr = 4'd0;
    logic [7:0] load_data = 8'd0;
    logic       load_ready;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       cpu_en;
    logic       cpu_rst_n;
    logic [1:0] state;

    td4_run_ctrl #(.TICK_DIV(TD), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .run_req    (run_req),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .cpu_ip     (cpu_ip),
        .load_valid (load_valid),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .cpu_en     (cpu_en),
        .cpu_rst_n  (cpu_rst_n),
        .state      (state)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;
        int cyc;
        int a;
        int d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_ip = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Toy CPU: advances its instruction pointer once per enabled cycle.
    always @(posedge clock) begin
        if (!cpu_rst_n) cpu_ip <= 4'd0;
        else if (cpu_en) cpu_ip <= cpu_ip + 4'd1;
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push_tick(input int c);
        exp_t e;
        e.kind = 0; e.cyc = c; e.a = model_ip; e.d = 0;
        exp_q.push_back(e);
        model_ip = (model_ip + 1) % 16;
    endtask

    task automatic push_write(input int c, input int a, input int d);
        exp_t e;
        e.kind = 1; e.cyc = c; e.a = a; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic check_event(input int kind, input int a, input int d);
        exp_t e;
        if (exp_q.size() == 0 || exp_q[0].kind != kind) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_%s: cycle %0d ip/addr %0d data %0d, none expected",
                     (kind == 1) ? "write" : "cpu_en", cyc, a, d);
        end else begin
            e = exp_q.pop_front();
            chk((kind == 1) ? "write_cycle" : "cpu_en_cycle", cyc, e.cyc);
            chk((kind == 1) ? "write_addr" : "cpu_en_ip", a, e.a);
            if (kind == 1) chk("write_data", d, e.d);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_event: kind %0d due at cycle %0d, not seen by %0d",
                         exp_q[0].kind, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (cpu_en) check_event(0, int'(cpu_ip), 0);
            if (ram_we) begin
                check_event(1, int'(ram_addr), int'(ram_wdata));
                chk("cpu_rst_n_during_write", cpu_rst_n, 0);
            end
        end
    end

    task automatic sc_run(input bit halt_on_tc);
        int n;
        int e0;
        int h;
        n = $urandom_range(2, 5);
        bp_en = 1'b0;
        run_req = 1'b1; tick(); run_req = 1'b0;
        e0 = cyc;
        for (int k = 1; k <= n; k++) push_tick(e0 + k * TD);
        chk("run_state", state, 1);
        wait_until(e0 + TD + 1);
        step_req = 1'b1; run_req = 1'b1; tick(); step_req = 1'b0; run_req = 1'b0;
        chk("run_ignores_step", state, 1);
        h = halt_on_tc ? TD : $urandom_range(1, TD - 1);
        wait_until(e0 + n * TD + h - 1);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_state", state, 0);
        chk("halt_cpu_en", cpu_en, 0);
        repeat (2 * TD) tick();
        chk("idle_after_halt", state, 0);
    endtask

    task automatic sc_bp();
        int m;
        int e0;
        m = $urandom_range(1, 3);
        bp_addr = 4'(model_ip + m);
        bp_en = 1'b1;
        run_req = 1'b1; tick(); run_req = 1'b0;
        e0 = cyc;
        for (int k = 1; k <= m; k++) push_tick(e0 + k * TD);
        wait_until(e0 + (m + 1) * TD);
        chk("bp_state_idle", state, 0);
        chk("bp_cpu_en", cpu_en, 0);
        repeat (3) tick();
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("halt_ignored_in_idle", state, 0);
        run_req = 1'b1; tick(); run_req = 1'b0;
        e0 = cyc;
        push_tick(e0 + TD);
        push_tick(e0 + 2 * TD);
        wait_until(e0 + 2 * TD);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("bp_resume_halt", state, 0);
        bp_en = 1'b0;
        repeat (2 * TD) tick();
    endtask

    task automatic sc_step();
        int e0;
        if ($urandom_range(0, 1) == 1) begin
            bp_en = 1'b1;
            bp_addr = 4'(model_ip);
        end
        step_req = 1'b1; tick(); step_req = 1'b0;
        e0 = cyc;
        push_tick(e0);
        chk("step_state", state, 2);
        halt_req = 1'b1; tick(); halt_req = 1'b0;
        chk("step_return", state, 0);
        repeat (2 * TD) tick();
        chk("step_single_pulse_idle", state, 0);
        bp_en = 1'b0;
    endtask

    task automatic sc_load(input bit with_run, input bit abort);
        int          nw;
        int          n0;
        int          g;
        logic [7:0]  dw [16];
        nw = abort ? $urandom_range(1, 6) : 16;
        for (int i = 0; i < 16; i++) dw[i] = 8'($urandom_range(0, 255));
        load_valid = 1'b1; load_addr = 4'd0; load_data = dw[0];
        run_req = with_run;
        n0 = cyc;
        chk("load_entry_no_write", ram_we, 0);
        tick();
        run_req = 1'b0;
        chk("load_state", state, 3);
        chk("load_ready_high", load_ready, 1);
        chk("load_cpu_rst_low", cpu_rst_n, 0);
        for (int i = 0; i < nw; i++) begin
            load_addr = 4'(i);
            load_data = dw[i];
            push_write(n0 + 1 + i, i, int'(dw[i]));
            g = 0;
            while (!load_ready && g < 4) begin tick(); g++; end
            tick();
        end
        if (abort) begin
            load_addr = 4'(nw);
            load_data = dw[nw];
            #1 reset = 1'b0;
            #1;
            chk("abort_ram_we", ram_we, 0);
            chk("abort_state", state, 0);
            chk("abort_load_ready", load_ready, 0);
            chk("abort_cpu_rst", cpu_rst_n, 0);
            load_valid = 1'b0;
            tick(); tick();
            reset = 1'b1;
            model_ip = 0;
            tick();
            chk("abort_release_cpu_rst", cpu_rst_n, 1);
            chk("abort_release_state", state, 0);
        end else begin
            load_valid = 1'b0;
            chk("load_hold_state", state, 3);
            chk("load_hold_cpu_rst", cpu_rst_n, 0);
            tick();
            chk("load_exit_state", state, 0);
            chk("load_exit_cpu_rst", cpu_rst_n, 1);
            model_ip = 0;
        end
        repeat (2) tick();
    endtask

    task automatic sc_reset_run();
        int e0;
        bp_en = 1'b0;
        run_req = 1'b1; tick(); run_req = 1'b0;
        e0 = cyc;
        wait_until(e0 + 2);
        #1 reset = 1'b0;
        #1;
        chk("rst_run_state", state, 0);
        chk("rst_run_cpu_en", cpu_en, 0);
        chk("rst_run_cpu_rst", cpu_rst_n, 0);
        tick(); tick();
        reset = 1'b1;
        model_ip = 0;
        tick();
        chk("rst_release_cpu_rst", cpu_rst_n, 1);
        repeat (3 * TD) tick();
        chk("rst_no_autorun", state, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("reset_state", state, 0);
        chk("reset_cpu_en", cpu_en, 0);
        chk("reset_load_ready", load_ready, 0);
        chk("reset_ram_we", ram_we, 0);
        chk("reset_cpu_rst", cpu_rst_n, 0);
        reset = 1'b1;
        tick();
        chk("release_cpu_rst", cpu_rst_n, 1);
        chk("release_state", state, 0);
        repeat (2) tick();

        sc_run(1'b1);
        sc_bp();
        sc_step();
        sc_load(1'b1, 1'b0);
        sc_reset_run();
        sc_load(1'b0, 1'b1);

        repeat (12) begin
            case ($urandom_range(0, 5))
                0: sc_run(1'b1);
                1: sc_run(1'b0);
                2: sc_bp();
                3: sc_step();
                4: sc_load($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                default: sc_reset_run();
            endcase
            repeat ($urandom_range(1, 4)) tick();
        end

        repeat (10) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/td4_run_ctrl.md
TD4_RUN_CTRL -- requirements
Module: td4_run_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 8, meaning clock cycles per CPU step in RUN; legal range 1..256.
REQ-002 SHALL have parameter CNT_W, default 8, meaning divider counter width.
REQ-003 SHALL have port clock  in  1  the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port run_req  in  1  one-cycle pulse requesting free run.
REQ-006 SHALL have port step_req  in  1  one-cycle pulse requesting a single instruction.
REQ-007 SHALL have port halt_req  in  1  one-cycle pulse requesting halt.
REQ-008 SHALL have port bp_en  in  1  breakpoint enable.
REQ-009 SHALL have port bp_addr  in  4  breakpoint instruction address.
REQ-010 SHALL have port cpu_ip  in  4  current CPU instruction pointer.
REQ-011 SHALL have port load_valid  in  1  program-load word valid.
REQ-012 SHALL have port load_addr  in  4  program-load word address.
REQ-013 SHALL have port load_data  in  8  program-load word, {OP[3:0], Imm[3:0]}.
REQ-014 SHALL have port load_ready  out  1  program-load word accepted when high together with load_valid.
REQ-015 SHALL have port ram_we  out  1  program RAM write strobe.
REQ-016 SHALL have port ram_addr  out  4  program RAM write address.
REQ-017 SHALL have port ram_wdata  out  8  program RAM write data.
REQ-018 SHALL have port cpu_en  out  1  one-cycle CPU clock enable; the CPU advances exactly one instruction per high cycle.
REQ-019 SHALL have port cpu_rst_n  out  1  active-low CPU reset.
REQ-020 SHALL have port state  out  2  encoding IDLE=00, RUN=01, STEP=10, LOAD=11.

Function
REQ-021 States: IDLE, RUN, STEP and LOAD; all outputs SHALL be registered except ram_we, ram_addr and ram_wdata.
REQ-022 IDLE SHALL move to LOAD on load_valid, else to RUN on run_req, else to STEP on step_req; priority is load > run > step.
REQ-023 RUN SHALL clear the divider counter on entry, increment it each cycle, and assert cpu_en for one cycle when the counter equals TICK_DIV-1, wrapping it to 0.
REQ-024 RUN SHALL return to IDLE on halt_req; halt_req coincident with a terminal count SHALL suppress that cpu_en.
REQ-025 Breakpoint: at a RUN terminal count with bp_en=1 and cpu_ip==bp_addr, the block SHALL suppress cpu_en and go to IDLE.
REQ-026 A skip flag SHALL be set on IDLE->RUN and cleared by the first cpu_en, so that a breakpoint at the resume address does not fire on the first tick.
REQ-027 STEP SHALL assert cpu_en for exactly one cycle (the cycle after entry), then return to IDLE, ignoring breakpoint and halt_req.
REQ-028 run_req and step_req SHALL be ignored outside IDLE; halt_req SHALL be ignored outside RUN.
REQ-029 LOAD SHALL drive load_ready=1 and cpu_rst_n=0; ram_we=load_valid&load_ready, ram_addr=load_addr, ram_wdata=load_data, combinationally.
REQ-030 The word present on the IDLE->LOAD transition cycle SHALL NOT be written; the source SHALL hold load_valid/addr/data until load_ready is high.
REQ-031 LOAD SHALL move to IDLE on the first cycle with load_valid=0; cpu_rst_n SHALL return high one cycle after leaving LOAD (registered).
REQ-032 In IDLE the block SHALL hold cpu_en=0, and cpu_ip SHALL be stable.

Reset
REQ-033 While reset=0: state=IDLE, cpu_en=0, load_ready=0, ram_we=0, cpu_rst_n=0, divider=0, skip flag=0.
REQ-034 On reset release, cpu_rst_n SHALL go high on the first clock edge; reset asserted mid-RUN or mid-LOAD SHALL abort immediately with no partial write.

Verification
REQ-035 TICK_DIV=4, run_req at cycle 0 -> cpu_en high at cycles 4, 8, 12; halt_req at cycle 12 -> no cpu_en at 12, state=00 at 13.
REQ-036 bp_en=1, bp_addr=3, cpu_ip counts 0,1,2,3 -> cpu_en suppressed when cpu_ip=3, state=IDLE; run_req again -> next tick issues cpu_en (skip), cpu_ip=4.
REQ-037 step_req in IDLE -> exactly one cpu_en pulse, state 10 for one cycle then 00; step_req in RUN -> no effect.
REQ-038 load_valid held with addr 0..15, data 8'h3C.. streamed -> 16 ram_we pulses, none on entry cycle; cpu_rst_n=0 throughout; valid drop -> IDLE, cpu_rst_n=1 next cycle.
REQ-039 load_valid and run_req same cycle in IDLE -> state LOAD, run ignored.
REQ-040 reset pulled low during RUN at count 2 -> cpu_en=0 and state=00 asynchronously; after release, no cpu_en until run_req.
